frame_store_responder: RTL and testbench

Responder end of the pixel-memory read interface used by the block-hunt image processor. Captures a 240x240 RGB 3:3:3 frame from the camera pixel stream into an inferred single-port-write / single-port-read RAM. On an analysis request it captures one clean, whole frame, then freezes it. While frozen it serves random-access (hcount, vcount) reads with fixed latency until the consumer signals completion.

---
 rtl/frame_store_responder.sv | 167 ++++++++++++++++
 tb/tb_frame_store_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/frame_store_responder.sv
// Frame store for the block-hunt pixel-memory interface: captures one whole camera
// frame on request, freezes it, and serves fixed-latency random-access reads.
module frame_store_responder #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] cam_pixel,
  input  logic [9:0] cam_hcount,
  input  logic [9:0] cam_vcount,
  input  logic       cam_valid,
  input  logic       cam_frame_start,
  input  logic       mem_request,
  input  logic       hunt_done,
  input  logic [9:0] mem_hcount,
  input  logic [9:0] mem_vcount,
  output logic [8:0] mem_pixel_data,
  output logic       frame_ready,
  output logic       short_frame,
  output logic [1:0] state_out
);

  localparam int          DEPTH    = WIDTH * HEIGHT;
  localparam logic [9:0]  W_LIM    = 10'(WIDTH);
  localparam logic [9:0]  H_LIM    = 10'(HEIGHT);
  localparam logic [15:0] FULL_CNT = 16'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, FILL = 2'd2, FROZEN = 2'd3} state_t;

  state_t      state_q, state_d;
  logic        frame_ready_q, frame_ready_d;
  logic        short_frame_q, short_frame_d;
  logic [15:0] cnt_q, cnt_d;

  logic        s1_valid_q, s1_valid_d;
  logic [8:0]  s1_pix_q, s1_pix_d;
  logic [9:0]  s1_h_q, s1_h_d, s1_v_q, s1_v_d;
  logic        s2_valid_q, s2_valid_d;
  logic [8:0]  s2_pix_q, s2_pix_d;
  logic [15:0] s2_addr_q, s2_addr_d;

  logic        rd_in_q, rd_in_d;
  logic [15:0] rd_addr_d;
  logic [8:0]  mem_pixel_data_q, mem_pixel_data_d;

  logic [15:0] wr_addr_calc, rd_addr_calc;
  logic        accept;

  logic [8:0]  ram [DEPTH];
  logic [8:0]  ram_rd_q;

  generate
    if (WIDTH == 240) begin : g_addr_shift
      logic [15:0] wv, rv;
      assign wv = {6'd0, s1_v_q};
      assign rv = {6'd0, mem_vcount};
      assign wr_addr_calc = (wv << 8) - (wv << 4) + {6'd0, s1_h_q};
      assign rd_addr_calc = (rv << 8) - (rv << 4) + {6'd0, mem_hcount};
    end else begin : g_addr_mult
      assign wr_addr_calc = {6'd0, s1_v_q} * 16'(WIDTH) + {6'd0, s1_h_q};
      assign rd_addr_calc = {6'd0, mem_vcount} * 16'(WIDTH) + {6'd0, mem_hcount};
    end
  endgenerate

  // Gating is decided at pipeline entry, so beats in flight at FILL->FROZEN still land.
  assign accept = (state_q == FILL) && cam_valid && (cam_hcount < W_LIM) && (cam_vcount < H_LIM);

  always_comb begin
    state_d       = state_q;
    frame_ready_d = frame_ready_q;
    short_frame_d = short_frame_q;
    cnt_d         = cnt_q;

    if (accept && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (mem_request) begin
          state_d       = ARM;
          short_frame_d = 1'b0;
        end
      end
      ARM: begin
        if (hunt_done) begin
          state_d = IDLE;
        end else if (cam_frame_start) begin
          state_d = FILL;
          cnt_d   = 16'd0;
        end
      end
      FILL: begin
        if (hunt_done) begin
          state_d = IDLE;
        end else if (cam_frame_start) begin
          state_d       = FROZEN;
          frame_ready_d = 1'b1;
          short_frame_d = (cnt_q != FULL_CNT);
        end
      end
      FROZEN: begin
        if (hunt_done) begin
          state_d       = IDLE;
          frame_ready_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    s1_valid_d = accept;
    s1_pix_d   = cam_pixel;
    s1_h_d     = cam_hcount;
    s1_v_d     = cam_vcount;
    s2_valid_d = s1_valid_q;
    s2_pix_d   = s1_pix_q;
    s2_addr_d  = wr_addr_calc;

    // Out-of-range reads park the address at 0 and are forced to zero at the output.
    rd_in_d          = (mem_hcount < W_LIM) && (mem_vcount < H_LIM);
    rd_addr_d        = rd_in_d ? rd_addr_calc : 16'd0;
    mem_pixel_data_d = rd_in_q ? ram_rd_q : 9'h000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      frame_ready_q    <= 1'b0;
      short_frame_q    <= 1'b0;
      cnt_q            <= 16'd0;
      s1_valid_q       <= 1'b0;
      s1_pix_q         <= 9'h000;
      s1_h_q           <= 10'd0;
      s1_v_q           <= 10'd0;
      s2_valid_q       <= 1'b0;
      s2_pix_q         <= 9'h000;
      s2_addr_q        <= 16'd0;
      rd_in_q          <= 1'b0;
      mem_pixel_data_q <= 9'h000;
    end else begin
      state_q          <= state_d;
      frame_ready_q    <= frame_ready_d;
      short_frame_q    <= short_frame_d;
      cnt_q            <= cnt_d;
      s1_valid_q       <= s1_valid_d;
      s1_pix_q         <= s1_pix_d;
      s1_h_q           <= s1_h_d;
      s1_v_q           <= s1_v_d;
      s2_valid_q       <= s2_valid_d;
      s2_pix_q         <= s2_pix_d;
      s2_addr_q        <= s2_addr_d;
      rd_in_q          <= rd_in_d;
      mem_pixel_data_q <= mem_pixel_data_d;
    end
  end

  // Read-first block RAM: a same-address write in this cycle is not visible to the read.
  always_ff @(posedge clk) begin
    if (s2_valid_q) ram[s2_addr_q] <= s2_pix_q;
    ram_rd_q <= ram[rd_addr_d];
  end

  assign mem_pixel_data = mem_pixel_data_q;
  assign frame_ready    = frame_ready_q;
  assign short_frame    = short_frame_q;
  assign state_out      = state_q;

endmodule

// File: tb/tb_frame_store_responder.sv
// Directed bench for frame_store_responder: capture, freeze, reads, short frame,
// asynchronous reset and abort paths, with hand-computed expectations.
module tb_frame_store_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] cam_pixel;
  logic [9:0] cam_hcount, cam_vcount;
  logic       cam_valid, cam_frame_start, mem_request, hunt_done;
  logic [9:0] mem_hcount, mem_vcount;
  logic [8:0] mem_pixel_data;
  logic       frame_ready, short_frame;
  logic [1:0] state_out;

  int checks = 0;
  int errors = 0;

  frame_store_responder dut (
    .clk(clk), .rst_n(rst_n),
    .cam_pixel(cam_pixel), .cam_hcount(cam_hcount), .cam_vcount(cam_vcount),
    .cam_valid(cam_valid), .cam_frame_start(cam_frame_start),
    .mem_request(mem_request), .hunt_done(hunt_done),
    .mem_hcount(mem_hcount), .mem_vcount(mem_vcount),
    .mem_pixel_data(mem_pixel_data), .frame_ready(frame_ready),
    .short_frame(short_frame), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic pulse_req();
    @(negedge clk); mem_request = 1'b1;
    @(negedge clk); mem_request = 1'b0;
  endtask

  task automatic pulse_fs();
    @(negedge clk); cam_frame_start = 1'b1;
    @(negedge clk); cam_frame_start = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk); hunt_done = 1'b1;
    @(negedge clk); hunt_done = 1'b0;
  endtask

  // Stream n beats starting at row v0; pixel is (h+v)&1FF unless use_k selects constant k.
  task automatic stream_beats(input int v0, input int n, input bit use_k, input logic [8:0] k);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cam_valid  = 1'b1;
      cam_hcount = 10'(i % 240);
      cam_vcount = 10'(v0 + i / 240);
      cam_pixel  = use_k ? k : 9'((i % 240) + v0 + i / 240);
    end
    @(negedge clk); cam_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic read_chk(input string tag, input int h, input int v, input logic [8:0] exp);
    @(negedge clk);
    mem_hcount = 10'(h);
    mem_vcount = 10'(v);
    @(posedge clk);
    @(posedge clk);
    #1 check(tag, 32'(mem_pixel_data), 32'(exp));
  endtask

  int         bb_h [4] = '{1, 2, 240, 100};
  int         bb_v [4] = '{0, 3, 0, 100};
  logic [8:0] bb_e [4] = '{9'd1, 9'd5, 9'd0, 9'd200};

  initial begin
    rst_n = 1'b0;
    cam_pixel = '0; cam_hcount = '0; cam_vcount = '0; cam_valid = 1'b0;
    cam_frame_start = 1'b0; mem_request = 1'b0; hunt_done = 1'b0;
    mem_hcount = '0; mem_vcount = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_ready", 32'(frame_ready), 32'd0);
    check("rst_short", 32'(short_frame), 32'd0);
    check("rst_data", 32'(mem_pixel_data), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Full capture
    pulse_req();
    check("arm_state", 32'(state_out), 32'd1);
    pulse_fs();
    check("fill_state", 32'(state_out), 32'd2);
    stream_beats(0, 57600, 1'b0, 9'h000);
    pulse_fs();
    check("frozen_state", 32'(state_out), 32'd3);
    check("full_ready", 32'(frame_ready), 32'd1);
    check("full_short", 32'(short_frame), 32'd0);
    read_chk("rd_0_0", 0, 0, 9'h000);
    read_chk("rd_239_239", 239, 239, 9'h1DE);
    read_chk("rd_17_5", 17, 5, 9'd22);

    // Frozen frame must not be overwritten by a later camera frame
    pulse_req();
    check("frozen_ignores_req", 32'(state_out), 32'd3);
    pulse_fs();
    stream_beats(0, 2400, 1'b1, 9'h1FF);
    pulse_fs();
    read_chk("frz_17_5", 17, 5, 9'd22);
    read_chk("frz_3_9", 3, 9, 9'd12);

    // Range
    read_chk("rd_240_0", 240, 0, 9'h000);
    read_chk("rd_0_240", 0, 240, 9'h000);
    read_chk("rd_1023_1023", 1023, 1023, 9'h000);

    // Back-to-back reads, one address per cycle
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) check($sformatf("b2b_%0d", k - 2), 32'(mem_pixel_data), 32'(bb_e[k-2]));
      if (k < 4) begin
        mem_hcount = 10'(bb_h[k]);
        mem_vcount = 10'(bb_v[k]);
      end
    end

    // Release
    @(negedge clk); hunt_done = 1'b1;
    @(posedge clk); #1;
    check("release_ready", 32'(frame_ready), 32'd0);
    check("release_state", 32'(state_out), 32'd0);
    @(negedge clk); hunt_done = 1'b0;

    // Asynchronous reset in the middle of a fill
    pulse_req();
    pulse_fs();
    stream_beats(0, 1000, 1'b1, 9'h0AA);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(state_out), 32'd0);
    check("async_rst_ready", 32'(frame_ready), 32'd0);
    check("async_rst_short", 32'(short_frame), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Beats in IDLE are dropped
    stream_beats(230, 2400, 1'b1, 9'h155);
    check("idle_state", 32'(state_out), 32'd0);

    // Short frame of 10 lines
    pulse_req();
    pulse_fs();
    stream_beats(0, 2400, 1'b0, 9'h000);
    pulse_fs();
    check("short_state", 32'(state_out), 32'd3);
    check("short_ready", 32'(frame_ready), 32'd1);
    check("short_flag", 32'(short_frame), 32'd1);
    read_chk("short_239_239", 239, 239, 9'h1DE);
    read_chk("short_3_2", 3, 2, 9'd5);
    read_chk("short_100_20", 100, 20, 9'd120);
    pulse_done();
    check("short_held_idle", 32'(short_frame), 32'd1);
    pulse_req();
    check("short_cleared", 32'(short_frame), 32'd0);
    check("req_arm", 32'(state_out), 32'd1);

    // Abort in ARM
    pulse_done();
    check("abort_arm", 32'(state_out), 32'd0);

    // Abort in FILL with simultaneous frame start
    pulse_req();
    pulse_fs();
    check("fill_again", 32'(state_out), 32'd2);
    @(negedge clk); hunt_done = 1'b1; cam_frame_start = 1'b1;
    @(posedge clk); #1;
    check("abort_fill_state", 32'(state_out), 32'd0);
    check("abort_fill_ready", 32'(frame_ready), 32'd0);
    @(negedge clk); hunt_done = 1'b0; cam_frame_start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_ready_later", 32'(frame_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
